// File: rtl/mem_loader.sv
// mem_loader -- boot-time program loader for the monocycle core.
//
// Accepts a byte stream on a valid/ready interface, assembles little-endian
// 32-bit instruction words and 64-bit data doublewords, and writes them into
// instruction memory and byte-addressed data memory. The core is held in
// reset (cpu_rst low) until the stream terminates cleanly.
//
// Stream: repeated sections of  hdr | cnt_lo | cnt_hi | payload
//   hdr 0xA5 -> instruction section (4-byte words)
//   hdr 0x5A -> data section (8-byte doublewords)
//   hdr 0xFF -> end of stream
//
// Optional feature: define MEM_LOADER_CHECKSUM_EN to require a trailing
// checksum byte after 0xFF (XOR of every payload byte of every section).
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-low reset
//   in_valid    stream byte present
//   in_data     stream byte
//   in_ready    loader can accept a byte
//   imem_we     one-cycle instruction write strobe
//   imem_addr   instruction word index
//   imem_wdata  instruction word
//   dmem_we     one-cycle data write strobe (8 bytes)
//   dmem_addr   data byte address, multiple of 8
//   dmem_wdata  doubleword, byte k -> dmem_addr+k
//   cpu_rst     active-low core reset, high only after a clean load
//   done        load completed (sticky)
//   err         protocol error (sticky)
//
// state     | meaning
// ----------+------------------------------------------------------
// S_HDR     | waiting for a section header or end marker
// S_CNT_LO  | waiting for count low byte
// S_CNT_HI  | waiting for count high byte; range-checks the count
// S_PAYLOAD | shifting payload bytes into words and writing them
// S_CHK     | waiting for checksum byte (checksum build only)
// S_DONE    | load finished, core released
// S_ERR     | protocol error, core held in reset forever

module mem_loader #(
  parameter  int IMEM_WORDS  = 64,
  parameter  int DMEM_DWORDS = 32,
  localparam int IAW         = $clog2(IMEM_WORDS),
  localparam int DAW         = $clog2(DMEM_DWORDS) + 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  output logic           in_ready,
  output logic           imem_we,
  output logic [IAW-1:0] imem_addr,
  output logic [31:0]    imem_wdata,
  output logic           dmem_we,
  output logic [DAW-1:0] dmem_addr,
  output logic [63:0]    dmem_wdata,
  output logic           cpu_rst,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {
    S_HDR,
    S_CNT_LO,
    S_CNT_HI,
    S_PAYLOAD,
`ifdef MEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic        is_data;   // section type latched at the header
  logic [7:0]  cnt_lo;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [2:0]  byte_cnt;
  logic [55:0] asm_q;     // previously received bytes; newest byte enters at the top

  logic        fire;
  logic [15:0] count_in;
  logic [16:0] depth_sel;
  logic        last_byte;
  logic        last_word;
  logic [63:0] asm_next;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q;
`endif

  assign fire      = in_valid && in_ready;
  assign count_in  = {in_data, cnt_lo};
  assign depth_sel = is_data ? 17'(DMEM_DWORDS) : 17'(IMEM_WORDS);
  assign last_byte = (byte_cnt == (is_data ? 3'd7 : 3'd3));
  assign last_word = (word_idx == count - 16'd1);
  // After 4 shifts the instruction word sits in the top 32 bits.
  assign asm_next  = {in_data, asm_q};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_HDR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b1;
    case (state_q)
      S_HDR: begin
        if (fire) begin
          if (in_data == 8'hA5 || in_data == 8'h5A) begin
            state_d = S_CNT_LO;
          end else if (in_data == 8'hFF) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_CNT_LO: begin
        if (fire) state_d = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (fire) begin
          if (count_in == 16'd0)                  state_d = S_HDR;
          else if ({1'b0, count_in} > depth_sel)  state_d = S_ERR;
          else                                    state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (fire && last_byte && last_word) state_d = S_HDR;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (fire) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: in_ready = 1'b0;
      S_ERR:  in_ready = 1'b0;
      default: begin
        state_d  = S_ERR;
        in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      is_data    <= 1'b0;
      cnt_lo     <= '0;
      count      <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      if (fire) begin
        case (state_q)
          S_HDR:    is_data <= (in_data == 8'h5A);
          S_CNT_LO: cnt_lo  <= in_data;
          S_CNT_HI: begin
            count    <= count_in;
            word_idx <= '0;
            byte_cnt <= '0;
          end
          S_PAYLOAD: begin
            asm_q <= asm_next[63:8];
            if (last_byte) begin
              byte_cnt <= '0;
              word_idx <= word_idx + 16'd1;
              if (is_data) begin
                dmem_we    <= 1'b1;
                dmem_addr  <= {word_idx[DAW-4:0], 3'b000};
                dmem_wdata <= asm_next;
              end else begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx[IAW-1:0];
                imem_wdata <= asm_next[63:32];
              end
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  // Running XOR spans all sections; only reset clears it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                            xor_q <= '0;
    else if (fire && state_q == S_PAYLOAD) xor_q <= xor_q ^ in_data;
  end
`endif

  assign done    = (state_q == S_DONE);
  assign cpu_rst = (state_q == S_DONE);
  assign err     = (state_q == S_ERR);

endmodule

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
module tb_mem_loader;
  localparam int IW = 64;
  localparam int DW = 32;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [63:0] dmem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  mem_loader #(.IMEM_WORDS(IW), .DMEM_DWORDS(DW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int addr; logic [63:0] data; int when; } wr_t;
  wr_t got_i[$], got_d[$], exp_i[$], exp_d[$];

  logic [7:0] stim[$];
  logic [7:0] stim_xor;
  int acc_cyc[$];
  int exp_end;   // 0 = still running, 1 = done, 2 = err
  int exp_last;

  // Write recorder: 'when' is the cycle the strobe was seen.
  always @(negedge CLK) begin
    if (RST) begin
      if (imem_we) got_i.push_back('{int'(imem_addr), {32'h0, imem_wdata}, cyc});
      if (dmem_we) got_d.push_back('{int'(dmem_addr), dmem_wdata, cyc});
    end
  end

  // ---------------- stimulus builders ----------------
  task automatic start_stream();
    stim.delete();
    stim_xor = 8'h00;
  endtask

  task automatic begin_sect(input logic [7:0] hdr, input int n);
    stim.push_back(hdr);
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
  endtask

  task automatic put_word(input logic [63:0] v, input int nb);
    for (int b = 0; b < nb; b++) begin
      stim.push_back(v[8*b +: 8]);
      stim_xor = stim_xor ^ v[8*b +: 8];
    end
  endtask

  task automatic end_stream();
    stim.push_back(8'hFF);
`ifdef MEM_LOADER_CHECKSUM_EN
    stim.push_back(stim_xor);
`endif
  endtask

  // ---------------- reference model: parses the byte stream ----------------
  // exp_*.when holds the stream index of the word's final byte.
  task automatic model();
    int p = 0;
    int n, bpw, depth;
    logic [63:0] d;
    logic [7:0] h;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0] xs = 8'h00;
`endif
    exp_i.delete(); exp_d.delete();
    exp_end = 0;
    exp_last = stim.size() - 1;
    while (p < stim.size()) begin
      h = stim[p];
      if (h == 8'hFF) begin
`ifdef MEM_LOADER_CHECKSUM_EN
        if (p + 1 < stim.size()) begin
          exp_last = p + 1;
          exp_end = (stim[p+1] == xs) ? 1 : 2;
        end else exp_last = p;
`else
        exp_last = p;
        exp_end = 1;
`endif
        return;
      end
      if (h != 8'hA5 && h != 8'h5A) begin
        exp_last = p; exp_end = 2; return;
      end
      if (p + 2 >= stim.size()) return;
      n = int'({stim[p+2], stim[p+1]});
      bpw = (h == 8'hA5) ? 4 : 8;
      depth = (h == 8'hA5) ? IW : DW;
      p += 3;
      if (n > depth) begin
        exp_last = p - 1; exp_end = 2; return;
      end
      for (int w = 0; w < n; w++) begin
        d = 64'h0;
        for (int b = 0; b < bpw; b++) begin
          if (p >= stim.size()) return;
          d = d | (64'(stim[p]) << (8 * b));
`ifdef MEM_LOADER_CHECKSUM_EN
          xs = xs ^ stim[p];
`endif
          p++;
        end
        if (h == 8'hA5) exp_i.push_back('{w, d, p - 1});
        else            exp_d.push_back('{w * 8, d, p - 1});
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply_reset();
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    got_i.delete(); got_d.delete();
    RST = 1'b1;
  endtask

  // Offers stim bytes; returns at the negedge one cycle after the last accept.
  task automatic send(input bit stall);
    int i = 0;
    int budget = 0;
    acc_cyc.delete();
    while (i < stim.size()) begin
      @(negedge CLK);
      if (stall && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = 8'($urandom);
      end else begin
        in_valid = 1'b1; in_data = stim[i];
      end
      if (!in_ready) break;
      if (in_valid) begin acc_cyc.push_back(cyc); i++; end
      budget++;
      if (budget > 5000) begin
        checks++; failures++;
        $display("FAIL send_timeout accepted=%0d required=%0d", i, stim.size());
        break;
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || cpu_rst !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl in_ready=%b cpu_rst=%b done=%b err=%b required 1 0 0 0", in_ready, cpu_rst, done, err);
    end
    checks++;
    if (imem_we !== 1'b0 || dmem_we !== 1'b0) begin
      failures++; $display("FAIL reset_we imem_we=%b dmem_we=%b required 0 0", imem_we, dmem_we);
    end
    checks++;
    if (imem_addr !== 6'h0 || dmem_addr !== 8'h0 || imem_wdata !== 32'h0 || dmem_wdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_bus ia=%h da=%h iw=%h dw=%h required zeros", imem_addr, dmem_addr, imem_wdata, dmem_wdata);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_instr(input bit stall, input string nm);
    apply_reset();
    start_stream();
    begin_sect(8'hA5, 2);
    put_word(64'h00500093, 4);
    put_word(64'h00A00113, 4);
    end_stream();
    model();
    send(stall);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b1 || err !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_end done=%b cpu_rst=%b err=%b in_ready=%b required 1 1 0 0", nm, done, cpu_rst, err, in_ready);
    end
    checks++;
    if (got_i.size() != 2 || got_d.size() != 0) begin
      failures++; $display("FAIL %s_count imem=%0d dmem=%0d required 2 0", nm, got_i.size(), got_d.size());
    end else begin
      checks++;
      if (got_i[0].data[31:0] !== 32'h00500093 || got_i[1].data[31:0] !== 32'h00A00113 ||
          got_i[0].addr != 0 || got_i[1].addr != 1) begin
        failures++;
        $display("FAIL %s_words got %0d:%h %0d:%h required 0:00500093 1:00a00113", nm,
                 got_i[0].addr, got_i[0].data[31:0], got_i[1].addr, got_i[1].data[31:0]);
      end
      foreach (exp_i[k]) begin
        checks++;
        if (got_i[k].when != acc_cyc[exp_i[k].when] + 1) begin
          failures++;
          $display("FAIL %s_latency word=%0d strobe_cyc=%0d required=%0d", nm, k, got_i[k].when, acc_cyc[exp_i[k].when] + 1);
        end
      end
    end
    if (!stall) begin
      checks++;
      if (acc_cyc.size() != stim.size() || acc_cyc[acc_cyc.size()-1] - acc_cyc[0] != stim.size() - 1) begin
        failures++; $display("FAIL %s_backtoback accepted=%0d span_not_one_per_cycle", nm, acc_cyc.size());
      end
    end
  endtask

  task automatic test_data();
    apply_reset();
    start_stream();
    begin_sect(8'h5A, 1);
    put_word(64'h0102030405060708, 8);
    end_stream();
    model();
    send(1'b0);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b1 || err !== 1'b0) begin
      failures++; $display("FAIL data_end done=%b cpu_rst=%b err=%b required 1 1 0", done, cpu_rst, err);
    end
    checks++;
    if (got_d.size() != 1 || got_i.size() != 0) begin
      failures++; $display("FAIL data_count dmem=%0d imem=%0d required 1 0", got_d.size(), got_i.size());
    end else if (got_d[0].addr != 0 || got_d[0].data !== 64'h0102030405060708 ||
                 got_d[0].when != acc_cyc[exp_d[0].when] + 1) begin
      failures++;
      $display("FAIL data_word got addr=%0d data=%h cyc=%0d required 0 0102030405060708 %0d",
               got_d[0].addr, got_d[0].data, got_d[0].when, acc_cyc[exp_d[0].when] + 1);
    end
  endtask

  task automatic test_err_hdr();
    apply_reset();
    start_stream();
    stim.push_back(8'h33);
    stim.push_back(8'hA5);
    send(1'b0);
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL err_hdr err=%b in_ready=%b cpu_rst=%b done=%b required 1 0 0 0", err, in_ready, cpu_rst, done);
    end
    start_stream();
    begin_sect(8'hA5, 1);
    put_word(64'h11223344, 4);
    end_stream();
    send(1'b0);
    checks++;
    if (err !== 1'b1 || cpu_rst !== 1'b0 || got_i.size() != 0) begin
      failures++; $display("FAIL err_sticky err=%b cpu_rst=%b writes=%0d required 1 0 0", err, cpu_rst, got_i.size());
    end
  endtask

  task automatic test_err_cnt();
    for (int c = 0; c < 2; c++) begin
      apply_reset();
      start_stream();
      begin_sect(c == 0 ? 8'hA5 : 8'h5A, c == 0 ? IW + 1 : DW + 1);
      put_word({$urandom, $urandom}, 8);
      model();
      send(1'b0);
      checks++;
      if (err !== 1'b1 || cpu_rst !== 1'b0 || exp_end != 2 || got_i.size() != 0 || got_d.size() != 0) begin
        failures++;
        $display("FAIL err_cnt%0d err=%b cpu_rst=%b writes=%0d/%0d required err=1 cpu_rst=0 no writes",
                 c, err, cpu_rst, got_i.size(), got_d.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start_stream();
    begin_sect(8'hA5, 2);
    stim.push_back(8'h93);
    stim.push_back(8'h00);
    send(1'b0);
    #2 RST = 1'b0;
    #1;
    checks++;
    if (cpu_rst !== 1'b0 || in_ready !== 1'b1 || imem_we !== 1'b0 || got_i.size() != 0) begin
      failures++;
      $display("FAIL reset_mid cpu_rst=%b in_ready=%b imem_we=%b writes=%0d required 0 1 0 0",
               cpu_rst, in_ready, imem_we, got_i.size());
    end
    @(negedge CLK);
    RST = 1'b1;
    test_instr(1'b0, "after_reset");
  endtask

  // Random sections, random lengths (including 0 and full depth), with/without stalls.
  task automatic test_random(input int iters, input bit full);
    for (int it = 0; it < iters; it++) begin
      int ns;
      apply_reset();
      start_stream();
      ns = full ? 3 : $urandom_range(1, 3);
      for (int s = 0; s < ns; s++) begin
        logic [7:0] h;
        int n, bpw;
        h = full ? ((s == 1) ? 8'h5A : 8'hA5) : (($urandom_range(0, 1) == 1) ? 8'h5A : 8'hA5);
        bpw = (h == 8'hA5) ? 4 : 8;
        if (full) n = (s == 0) ? IW : (s == 1) ? DW : 1;
        else      n = $urandom_range(0, 4);
        begin_sect(h, n);
        for (int w = 0; w < n; w++) put_word({$urandom, $urandom}, bpw);
      end
      end_stream();
      model();
      send(it[0]);
      checks++;
      if (done !== (exp_end == 1) || cpu_rst !== (exp_end == 1) || err !== (exp_end == 2)) begin
        failures++; $display("FAIL rand%0d_end done=%b cpu_rst=%b err=%b exp_end=%0d", it, done, cpu_rst, err, exp_end);
      end
      checks++;
      if (got_i.size() != exp_i.size() || got_d.size() != exp_d.size()) begin
        failures++;
        $display("FAIL rand%0d_count imem=%0d dmem=%0d required %0d %0d", it, got_i.size(), got_d.size(), exp_i.size(), exp_d.size());
      end else begin
        foreach (exp_i[k]) begin
          checks++;
          if (got_i[k].addr != exp_i[k].addr || got_i[k].data !== exp_i[k].data || got_i[k].when != acc_cyc[exp_i[k].when] + 1) begin
            failures++;
            $display("FAIL rand%0d_imem%0d got %0d:%h@%0d required %0d:%h@%0d", it, k, got_i[k].addr, got_i[k].data,
                     got_i[k].when, exp_i[k].addr, exp_i[k].data, acc_cyc[exp_i[k].when] + 1);
          end
        end
        foreach (exp_d[k]) begin
          checks++;
          if (got_d[k].addr != exp_d[k].addr || got_d[k].data !== exp_d[k].data || got_d[k].when != acc_cyc[exp_d[k].when] + 1) begin
            failures++;
            $display("FAIL rand%0d_dmem%0d got %0d:%h@%0d required %0d:%h@%0d", it, k, got_d[k].addr, got_d[k].data,
                     got_d[k].when, exp_d[k].addr, exp_d[k].data, acc_cyc[exp_d[k].when] + 1);
          end
        end
        if (full) begin
          checks++;
          if (got_d.size() != DW || got_d[DW-1].addr != 8 * (DW - 1) || got_i[IW-1].addr != IW - 1) begin
            failures++; $display("FAIL full_depth last dmem/imem address wrong, dmem writes=%0d", got_d.size());
          end
        end
      end
    end
  endtask

`ifdef MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    apply_reset();
    start_stream();
    begin_sect(8'hA5, 2);
    put_word(64'h00500093, 4);
    put_word(64'h00A00113, 4);
    end_stream();
    stim[stim.size()-1] = stim_xor ^ 8'h01;
    send(1'b0);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b0) begin
      failures++; $display("FAIL checksum_bad err=%b done=%b cpu_rst=%b required 1 0 0", err, done, cpu_rst);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_instr(1'b0, "instr");
    test_data();
    test_instr(1'b1, "stall");
    test_err_hdr();
    test_err_cnt();
    test_reset_mid();
    test_random(1, 1'b1);
    test_random(8, 1'b0);
`ifdef MEM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
